// File: rtl/dl_rom_pkg.sv
// rtl/dl_rom_pkg.sv - shared types, region map and address decode for the download router
//
// Purpose: FSM state enum, ROM region enum, region base/limit constants,
//          the FIFO entry struct {sel, addr, data} and the push-time decode.
// Ports:   none (package).
package dl_rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dl_state_e;

  typedef enum logic [1:0] {
    REGION_CPU  = 2'd0,
    REGION_SND  = 2'd1,
    REGION_GFX  = 2'd2,
    REGION_PROM = 2'd3
  } region_e;

  localparam logic [17:0] CPU_BASE   = 18'h00000;
  localparam logic [17:0] CPU_LIMIT  = 18'h17FFF;
  localparam logic [17:0] SND_BASE   = 18'h18000;
  localparam logic [17:0] SND_LIMIT  = 18'h1FFFF;
  localparam logic [17:0] GFX_BASE   = 18'h20000;
  localparam logic [17:0] GFX_LIMIT  = 18'h2FFFF;
  localparam logic [17:0] PROM_BASE  = 18'h30000;
  localparam logic [17:0] PROM_LIMIT = 18'h3FFFF;

  typedef struct packed {
    region_e     sel;
    logic [16:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;

  // Every region is at most 0x18000 bytes, so the offset always fits 17 bits.
  function automatic fifo_entry_t decode_entry(input logic [17:0] addr, input logic [7:0] data);
    fifo_entry_t e;
    e.data = data;
    if (addr <= CPU_LIMIT) begin
      e.sel  = REGION_CPU;
      e.addr = 17'(addr - CPU_BASE);
    end else if (addr <= SND_LIMIT) begin
      e.sel  = REGION_SND;
      e.addr = 17'(addr - SND_BASE);
    end else if (addr <= GFX_LIMIT) begin
      e.sel  = REGION_GFX;
      e.addr = 17'(addr - GFX_BASE);
    end else begin
      e.sel  = REGION_PROM;
      e.addr = 17'(addr - PROM_BASE);
    end
    return e;
  endfunction

endpackage

// File: rtl/dl_fifo.sv
// rtl/dl_fifo.sv - synchronous FIFO between the download port and the ROM write port
//
// Purpose: FIFO_DEPTH-entry buffer of entry_t with wrap-bit pointers.
// Ports:   clk_sys, reset_n (async, active-low)
//          push, push_data  - write side; accepted when not full or popping this cycle
//          pop              - read side; ignored when empty
//          head             - entry at the read pointer (valid when !empty)
//          full, empty      - occupancy flags
module dl_fifo #(
  parameter int  FIFO_DEPTH = 4,
  parameter type entry_t    = logic [7:0]
) (
  input  logic   clk_sys,
  input  logic   reset_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra MSB distinguishes a full buffer from an empty one when the
  // index bits coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers reset to empty, so stale contents
  // are never presented.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/dl_rom_router.sv
// rtl/dl_rom_router.sv - routes download bytes to the four ROM regions through a FIFO
//
// Purpose: tracks a download session (IDLE/LOAD/DRAIN/DONE), decodes each
//          accepted byte to {region, offset}, buffers it and presents it on
//          a valid/ready ROM write port. Optional macro DL_CHECKSUM_EN adds a
//          16-bit running byte sum; without it checksum is tied to zero.
// Ports:   clk_sys, reset_n (async, active-low)
//          dn_active, dn_wr, dn_addr[ADDR_W], dn_data[8]      - download side
//          rom_wr, rom_ready, rom_sel[2], rom_addr[17], rom_data[8] - ROM side
//          busy, done, overflow (sticky), byte_count[ADDR_W+1], checksum[16]
module dl_rom_router
  import dl_rom_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 18
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              dn_active,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  output logic              rom_wr,
  input  logic              rom_ready,
  output logic [1:0]        rom_sel,
  output logic [16:0]       rom_addr,
  output logic [7:0]        rom_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   byte_count,
  output logic [15:0]       checksum
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  dl_state_e   state_q;
  dl_state_e   state_d;
  logic        act_q;
  logic        act_rise;
  logic        act_fall;
  logic        enter_load;
  logic        wr_attempt;
  logic        push;
  logic        pop;
  logic        drop;
  logic        fifo_full;
  logic        fifo_empty;
  fifo_entry_t push_entry;
  fifo_entry_t head;

  assign act_rise   = dn_active && !act_q;
  assign act_fall   = !dn_active && act_q;
  assign enter_load = (state_d == ST_LOAD) && (state_q != ST_LOAD);

  // A pop frees a slot in the same edge, so a full FIFO still takes a byte
  // when the ROM side is draining.
  assign wr_attempt = (state_q == ST_LOAD) && dn_wr;
  assign pop        = !fifo_empty && rom_ready;
  assign push       = wr_attempt && (!fifo_full || pop);
  assign drop       = wr_attempt && fifo_full && !pop;

  assign push_entry = decode_entry(dn_addr[17:0], dn_data);

  dl_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .entry_t    (fifo_entry_t)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Payload is forced to zero while nothing is queued so the port idles clean.
  assign rom_wr   = !fifo_empty;
  assign rom_sel  = rom_wr ? head.sel  : 2'b00;
  assign rom_addr = rom_wr ? head.addr : 17'h00000;
  assign rom_data = rom_wr ? head.data : 8'h00;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= dn_active;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (act_rise) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        busy = 1'b1;
        if (act_fall) state_d = ST_LOAD == ST_LOAD ? ST_DRAIN : ST_LOAD;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (act_rise)        state_d = ST_LOAD;
        else if (fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (act_rise) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      byte_count <= '0;
      overflow   <= 1'b0;
    end else if (enter_load) begin
      byte_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push && (byte_count != '1)) byte_count <= byte_count + CNT_ONE;
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef DL_CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      checksum_q <= 16'h0000;
    end else if (enter_load) begin
      checksum_q <= 16'h0000;
    end else if (push) begin
      checksum_q <= checksum_q + {8'h00, dn_data};
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_dl_rom_router.sv
// tb/tb_dl_rom_router.sv - self-checking bench for dl_rom_router
module tb_dl_rom_router;

  localparam int DEPTH    = 4;
  localparam int AW       = 18;
  localparam int CNT_MAX  = (1 << (AW + 1)) - 1;
  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_DONE  = 3;

  logic          clk_sys   = 1'b0;
  logic          reset_n   = 1'b0;
  logic          dn_active = 1'b0;
  logic          dn_wr     = 1'b0;
  logic [AW-1:0] dn_addr   = '0;
  logic [7:0]    dn_data   = 8'h00;
  logic          rom_ready = 1'b0;
  logic          rom_wr;
  logic [1:0]    rom_sel;
  logic [16:0]   rom_addr;
  logic [7:0]    rom_data;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW:0]   byte_count;
  logic [15:0]   checksum;

  int vectors     = 0;
  int miscompares = 0;
  int k;

  // Reference model: session phase, accepted-byte statistics and a queue of
  // the {sel, offset, data} words the ROM port still owes.
  int          m_phase   = PH_IDLE;
  logic        m_prev_act = 1'b0;
  int          m_cnt     = 0;
  logic [15:0] m_cks     = 16'h0000;
  logic        m_ovf     = 1'b0;
  logic [26:0] mq[$];

  dl_rom_router #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .dn_active  (dn_active),
    .dn_wr      (dn_wr),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .rom_wr     (rom_wr),
    .rom_ready  (rom_ready),
    .rom_sel    (rom_sel),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .byte_count (byte_count),
    .checksum   (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_checksum();
`ifdef DL_CHECKSUM_EN
    return m_cks;
`else
    return 16'h0000;
`endif
  endfunction

  // Advance the model by the rules for one clock edge, apply the edge, then
  // compare every observable output against the model.
  task automatic tick();
    bit          rise;
    bit          fall;
    bit          was_empty;
    bit          do_pop;
    bit          do_push;
    int          a;
    logic [1:0]  s;
    logic [16:0] off;
    logic [26:0] h;
    rise      = dn_active && !m_prev_act;
    fall      = !dn_active && m_prev_act;
    was_empty = (mq.size() == 0);
    do_pop    = !was_empty && rom_ready;
    do_push   = 1'b0;
    if (m_phase == PH_LOAD && dn_wr) begin
      if (mq.size() < DEPTH || do_pop) do_push = 1'b1;
      else m_ovf = 1'b1;
    end
    if (do_pop) mq.delete(0);
    if (do_push) begin
      a = int'(dn_addr);
      if (a < 'h18000)      begin s = 2'd0; off = 17'(a); end
      else if (a < 'h20000) begin s = 2'd1; off = 17'(a - 'h18000); end
      else if (a < 'h30000) begin s = 2'd2; off = 17'(a - 'h20000); end
      else                  begin s = 2'd3; off = 17'(a - 'h30000); end
      mq.push_back({s, off, dn_data});
      if (m_cnt < CNT_MAX) m_cnt++;
      m_cks = m_cks + {8'h00, dn_data};
    end
    case (m_phase)
      PH_IDLE:  if (rise) m_phase = PH_LOAD;
      PH_LOAD:  if (fall) m_phase = PH_DRAIN;
      PH_DRAIN: if (rise) m_phase = PH_LOAD; else if (was_empty) m_phase = PH_DONE;
      default:  if (rise) m_phase = PH_LOAD;
    endcase
    if (rise && m_phase == PH_LOAD) begin
      m_cnt = 0;
      m_cks = 16'h0000;
      m_ovf = 1'b0;
    end
    m_prev_act = dn_active;
    @(posedge clk_sys);
    #1;
    check("rom_wr", 32'(rom_wr), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      h = mq[0];
      check("rom_sel",  32'(rom_sel),  32'(h[26:25]));
      check("rom_addr", 32'(rom_addr), 32'(h[24:8]));
      check("rom_data", 32'(rom_data), 32'(h[7:0]));
    end
    check("byte_count", 32'(byte_count), 32'(m_cnt));
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("checksum",   32'(checksum),   32'(exp_checksum()));
    check("busy",       32'(busy),       32'(m_phase == PH_LOAD || m_phase == PH_DRAIN));
    check("done",       32'(done),       32'(m_phase == PH_DONE));
  endtask

  task automatic cyc(input logic act, input logic wr, input logic [AW-1:0] a,
                     input logic [7:0] d, input logic rdy);
    dn_active = act;
    dn_wr     = wr;
    dn_addr   = a;
    dn_data   = d;
    rom_ready = rdy;
    tick();
  endtask

  // Reset lands mid-cycle; outputs must clear before any further edge.
  task automatic mid_reset();
    reset_n = 1'b0;
    #1;
    check("rst_rom_wr",     32'(rom_wr),     32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    check("rst_checksum",   32'(checksum),   32'd0);
    check("rst_rom_sel",    32'(rom_sel),    32'd0);
    check("rst_rom_addr",   32'(rom_addr),   32'd0);
    check("rst_rom_data",   32'(rom_data),   32'd0);
    mq.delete();
    m_phase    = PH_IDLE;
    m_prev_act = 1'b0;
    m_cnt      = 0;
    m_cks      = 16'h0000;
    m_ovf      = 1'b0;
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    @(posedge clk_sys);
    #1;
    mid_reset();

    // First byte lands at the top of the CPU region.
    cyc(1, 0, '0, 8'h00, 1);
    cyc(1, 1, 18'h17FFF, 8'hAA, 1);
    check("r26_rom_wr", 32'(rom_wr),     32'd1);
    check("r26_sel",    32'(rom_sel),    32'd0);
    check("r26_addr",   32'(rom_addr),   32'h17FFF);
    check("r26_data",   32'(rom_data),   32'hAA);
    check("r26_count",  32'(byte_count), 32'd1);
    cyc(1, 0, '0, 8'h00, 1);

    // Region boundaries: sound base, PROM top.
    cyc(1, 1, 18'h18000, 8'h55, 0);
    cyc(1, 1, 18'h3FFFF, 8'h01, 0);
    check("r27_sel_a",  32'(rom_sel),  32'd1);
    check("r27_addr_a", 32'(rom_addr), 32'h0);
    cyc(1, 0, '0, 8'h00, 1);
    check("r27_sel_b",  32'(rom_sel),  32'd3);
    check("r27_addr_b", 32'(rom_addr), 32'hFFFF);
    cyc(1, 0, '0, 8'h00, 1);

    // Overflow: five writes into a stalled four-entry FIFO.
    cyc(0, 0, '0, 8'h00, 1);
    cyc(0, 0, '0, 8'h00, 1);
    check("r28_done", 32'(done), 32'd1);
    cyc(1, 0, '0, 8'h00, 0);
    check("r28_cleared", 32'(byte_count), 32'd0);
    for (int i = 0; i < 5; i++) cyc(1, 1, AW'(i * 'h9000), 8'(8'h10 + i), 0);
    check("r28_overflow", 32'(overflow),   32'd1);
    check("r28_count",    32'(byte_count), 32'd4);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (rom_wr) begin
        check("r28_order", 32'(rom_data), 32'(16 + k));
        k++;
      end
      cyc(1, 0, '0, 8'h00, 1);
    end
    check("r28_xfers", 32'(k), 32'd4);

    // Full FIFO with simultaneous push and pop.
    cyc(0, 0, '0, 8'h00, 1);
    cyc(0, 0, '0, 8'h00, 1);
    cyc(1, 0, '0, 8'h00, 0);
    check("r29_ovf_clear", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1, 1, AW'('h20000 + i), 8'(8'h20 + i), 0);
    cyc(1, 1, 18'h20004, 8'h24, 1);
    check("r29_overflow", 32'(overflow),   32'd0);
    check("r29_count",    32'(byte_count), 32'd5);
    check("r29_head",     32'(rom_data),   32'h21);
    cyc(1, 1, 18'h20005, 8'h25, 0);
    check("r29_still_full", 32'(overflow), 32'd1);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      if (rom_wr) k++;
      cyc(1, 0, '0, 8'h00, 1);
    end
    check("r29_xfers", 32'(k), 32'd4);

    // Randomised traffic including session restarts and writes outside LOAD.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0) ? ~dn_active : dn_active,
          1'($urandom_range(0, 2) != 0),
          AW'($urandom_range(0, 'h3FFFF)),
          8'($urandom),
          1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, '0, 8'h00, 1);

    // 256 x 0xFF, streamed with the ROM always ready.
    cyc(1, 0, '0, 8'h00, 1);
    for (int i = 0; i < 256; i++) cyc(1, 1, AW'(i), 8'hFF, 1);
    check("r30_count", 32'(byte_count), 32'd256);
`ifdef DL_CHECKSUM_EN
    check("r30_checksum", 32'(checksum), 32'(16'((256 * 255) % 65536)));
`else
    check("r30_checksum", 32'(checksum), 32'd0);
`endif
    for (int i = 0; i < 4; i++) cyc(0, 0, '0, 8'h00, 1);
    check("r30_done", 32'(done), 32'd1);

    // Reset while DRAIN still holds three entries.
    cyc(1, 0, '0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, AW'('h30000 + i), 8'(8'h40 + i), 0);
    cyc(0, 0, '0, 8'h00, 0);
    cyc(0, 0, '0, 8'h00, 0);
    check("r31_pre_busy",   32'(busy),   32'd1);
    check("r31_pre_rom_wr", 32'(rom_wr), 32'd1);
    mid_reset();
    for (int i = 0; i < 6; i++) cyc(0, 0, '0, 8'h00, 1);
    check("r31_no_write", 32'(rom_wr), 32'd0);
    check("r31_idle",     32'(busy),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
